// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;
    localparam int DATA_W = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;
endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and data-bit counter for the UART receiver.
module uart_rx_edge_bit_counter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       bit_en,
    input  logic [5:0] prescale,
    output logic [5:0] edge_cnt,
    output logic [2:0] bit_cnt,
    output logic       bit_done
);
    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    // Any prescale value terminates a bit within 64 cycles because the
    // 6-bit counter always reaches prescale-1 before wrapping.
    assign bit_done = enable && (edge_cnt_q == prescale - 6'd1);

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!enable)
            edge_cnt_d = '0;
        else if (bit_done)
            edge_cnt_d = '0;
        else
            edge_cnt_d = edge_cnt_q + 6'd1;

        if (!bit_en)
            bit_cnt_d = '0;
        else if (bit_done)
            bit_cnt_d = bit_cnt_q + 3'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, data shifter, parity/stop checking.
module uart_rx_ctrl
    import uart_rx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    output logic              data_samp_en,
    output logic [5:0]        edge_cnt,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err
);
    rx_state_e          state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  p_data_q, p_data_d;
    logic [5:0]         prescale_q, prescale_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic               frame_err_q, frame_err_d;
    logic               samp_en_q, samp_en_d;
    logic               data_valid_q, data_valid_d;
    logic               par_err_q, par_err_d;
    logic               stp_err_q, stp_err_d;

    logic [2:0]         bit_cnt;
    logic               bit_done;
    logic               exp_par;

    uart_rx_edge_bit_counter u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (state_q != IDLE),
        .bit_en   (state_q == DATA),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    assign exp_par = (^shift_q) ^ (par_typ_q == PAR_ODD);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        case (state_q)
            IDLE: if (!RX_IN) begin
                // Frame configuration is frozen for the whole frame.
                state_d     = START;
                prescale_d  = Prescale;
                par_en_d    = PAR_EN;
                par_typ_d   = PAR_TYP;
                frame_err_d = 1'b0;
            end
            START: if (bit_done)
                state_d = sampled_bit ? IDLE : DATA;
            DATA: if (bit_done) begin
                shift_d = {sampled_bit, shift_q[DATA_W-1:1]};
                if (bit_cnt == 3'd7)
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: if (bit_done) begin
                if (sampled_bit != exp_par) begin
                    frame_err_d = 1'b1;
                    par_err_d   = 1'b1;
                end
                state_d = STOP;
            end
            STOP: if (bit_done) begin
                if (!sampled_bit)
                    stp_err_d = 1'b1;
                else if (!frame_err_q) begin
                    p_data_d     = shift_q;
                    data_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Held through every non-idle cycle so the sampler keeps its votes.
        samp_en_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            p_data_q     <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            samp_en_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            frame_err_q  <= frame_err_d;
            samp_en_q    <= samp_en_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign data_samp_en = samp_en_q;
    assign P_DATA       = p_data_q;
    assign data_valid   = data_valid_q;
    assign par_err      = par_err_q;
    assign stp_err      = stp_err_q;
endmodule
